// File: rtl/led_frame_loader.sv
// Serial-to-frame loader for a 16x16 1-bit LED panel. It shifts row words in
// from a 3-wire link and swaps a double-buffered frame store at frame boundaries.
module led_frame_loader #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter bit          SWAP_ON_SYNC = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ser_clk,
  input  logic        i_ser_data,
  input  logic        i_ser_cs_n,
  input  logic        i_frame_sync,
  input  logic [3:0]  i_rd_addr,
  output logic [15:0] o_rd_data,
  output logic        o_swap_pending,
  output logic        o_frame_done,
  output logic        o_overrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_COMMIT  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdat_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  logic [2:0]  r_state;
  logic [3:0]  r_bit_cnt;
  logic [3:0]  r_wr_row;
  logic [15:0] r_shreg;
  logic        r_front;
  logic        r_swap_pending;
  logic        r_frame_done;
  logic        r_overrun;
  logic [15:0] r_rd_data;
  // Entry {bank,row}: bank 0 occupies 0..15, bank 1 occupies 16..31.
  logic [15:0] r_mem [0:31];

  logic w_sclk;
  logic w_sdat;
  logic w_cs_n;
  logic w_rise;
  logic w_cs_fall;
  logic w_swap_ev;

  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_sdat    = r_sdat_sync[SYNC_STAGES-1];
  assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_prev;
  assign w_cs_fall = ~w_cs_n & r_cs_prev;
  assign w_swap_ev = SWAP_ON_SYNC ? i_frame_sync : 1'b1;

  // Pin synchronizers and edge-detect history.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_sync <= '0;
      r_sdat_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_ser_clk};
      r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], i_ser_data};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_ser_cs_n};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs_n;
    end
  end

  // Load FSM, back-buffer writes and swap control.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_bit_cnt      <= 4'd0;
      r_wr_row       <= 4'd0;
      r_shreg        <= 16'd0;
      r_front        <= 1'b0;
      r_swap_pending <= 1'b0;
      r_frame_done   <= 1'b0;
      r_overrun      <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= 16'd0;
      end
    end else begin
      r_frame_done <= 1'b0;
      // A new frame opening while one still waits is lost, whatever the state.
      if (w_cs_fall && r_swap_pending) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            if (r_swap_pending) begin
              r_state <= S_DISCARD;
            end else begin
              r_state   <= S_SHIFT;
              r_bit_cnt <= 4'd0;
              r_wr_row  <= 4'd0;
            end
          end
        end
        S_SHIFT: begin
          if (w_cs_n) begin
            r_state <= S_IDLE;
          end else if (w_rise) begin
            r_shreg   <= {r_shreg[14:0], w_sdat};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd15) begin
              r_state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          r_mem[{~r_front, r_wr_row}] <= r_shreg;
          if (r_wr_row == 4'd15) begin
            r_wr_row       <= 4'd0;
            r_swap_pending <= 1'b1;
            r_state        <= S_WAIT;
          end else begin
            r_wr_row <= r_wr_row + 4'd1;
            r_state  <= S_SHIFT;
          end
        end
        S_WAIT: begin
          if (w_swap_ev) begin
            r_front        <= ~r_front;
            r_swap_pending <= 1'b0;
            r_frame_done   <= 1'b1;
            r_state        <= w_cs_n ? S_IDLE : S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (w_cs_n) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered front-buffer read port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data <= 16'd0;
    end else begin
      r_rd_data <= r_mem[{r_front, i_rd_addr}];
    end
  end

  assign o_rd_data      = r_rd_data;
  assign o_swap_pending = r_swap_pending;
  assign o_frame_done   = r_frame_done;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed-sequence bench with random frame contents, checked against a
// two-image frame-store model (front shown, back being filled).
module tb_led_frame_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ser_clk;
  logic        ser_data;
  logic        ser_cs_n;
  logic        frame_sync;
  logic [3:0]  rd_addr;
  logic [15:0] rd_a, rd_b;
  logic        pend_a, pend_b, done_a, done_b, ovr_a, ovr_b;

  int n_vec = 0;
  int n_err = 0;
  int cnt_done_a = 0;
  int cnt_done_b = 0;
  int snap_a, snap_b;

  logic [15:0] tx_words [16];
  logic [15:0] m_front  [16];
  logic [15:0] m_back   [16];

  always #5 clk = ~clk;

  led_frame_loader #(.SYNC_STAGES(3), .SWAP_ON_SYNC(1'b1)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_ser_clk(ser_clk), .i_ser_data(ser_data),
    .i_ser_cs_n(ser_cs_n), .i_frame_sync(frame_sync), .i_rd_addr(rd_addr),
    .o_rd_data(rd_a), .o_swap_pending(pend_a), .o_frame_done(done_a),
    .o_overrun(ovr_a)
  );

  led_frame_loader #(.SYNC_STAGES(2), .SWAP_ON_SYNC(1'b0)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_ser_clk(ser_clk), .i_ser_data(ser_data),
    .i_ser_cs_n(ser_cs_n), .i_frame_sync(frame_sync), .i_rd_addr(rd_addr),
    .o_rd_data(rd_b), .o_swap_pending(pend_b), .o_frame_done(done_b),
    .o_overrun(ovr_b)
  );

  always @(posedge clk) begin
    if (done_a === 1'b1) cnt_done_a <= cnt_done_a + 1;
    if (done_b === 1'b1) cnt_done_b <= cnt_done_b + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic tx_bit(input int i);
    logic [15:0] w;
    if (i >= 256) return 1'b0;
    w = tx_words[i / 16];
    return w[15 - (i % 16)];
  endfunction

  task automatic send_bits(input int nbits, input int ph);
    for (int i = 0; i < nbits; i++) begin
      ser_data = tx_bit(i);
      clk_wait(ph);
      ser_clk = 1'b1;
      clk_wait(ph);
      ser_clk = 1'b0;
    end
    clk_wait(ph);
  endtask

  task automatic cs_low();
    ser_cs_n = 1'b0;
    clk_wait(5);
  endtask

  task automatic cs_high();
    ser_cs_n = 1'b1;
    clk_wait(5);
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    clk_wait(1);
    frame_sync = 1'b0;
    clk_wait(3);
  endtask

  task automatic randomize_frame();
    for (int r = 0; r < 16; r++) tx_words[r] = 16'($urandom);
  endtask

  // Only whole 16-bit row words ever reach the back image.
  task automatic model_commit(input int nbits);
    int rows;
    rows = nbits / 16;
    if (rows > 16) rows = 16;
    for (int r = 0; r < rows; r++) m_back[r] = tx_words[r];
  endtask

  task automatic model_swap();
    logic [15:0] t;
    for (int r = 0; r < 16; r++) begin
      t = m_front[r];
      m_front[r] = m_back[r];
      m_back[r] = t;
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 16; r++) begin
      m_front[r] = 16'd0;
      m_back[r]  = 16'd0;
    end
  endtask

  task automatic check_front(input string tag, input bit use_b);
    for (int r = 0; r < 16; r++) begin
      rd_addr = 4'(r);
      clk_wait(1);
      if (use_b) check($sformatf("%s_b_row%0d", tag, r), rd_b, m_back[r]);
      else       check($sformatf("%s_a_row%0d", tag, r), rd_a, m_front[r]);
    end
  endtask

  initial begin
    int ph;
    reset = 1'b1; ser_clk = 1'b0; ser_data = 1'b0; ser_cs_n = 1'b1;
    frame_sync = 1'b0; rd_addr = 4'd0;
    model_clear();
    clk_wait(3);
    reset = 1'b0;
    clk_wait(2);

    // 1: reset state
    check("rst_pend_a", {15'd0, pend_a}, 16'd0);
    check("rst_done_a", {15'd0, done_a}, 16'd0);
    check("rst_ovr_a",  {15'd0, ovr_a},  16'd0);
    check("rst_pend_b", {15'd0, pend_b}, 16'd0);
    check_front("rst", 1'b0);

    // 2: walking-one frame, swap on frame_sync
    for (int r = 0; r < 16; r++) tx_words[r] = 16'h0001 << r;
    ph = $urandom_range(2, 4);
    cs_low();
    send_bits(256, ph);
    cs_high();
    model_commit(256);
    check("t2_pend_before", {15'd0, pend_a}, 16'd1);
    snap_a = cnt_done_a;
    pulse_sync();
    model_swap();
    check("t2_done_once", 16'(cnt_done_a - snap_a), 16'd1);
    check("t2_pend_after", {15'd0, pend_a}, 16'd0);
    rd_addr = 4'd5;
    clk_wait(1);
    check("t2_row5", rd_a, 16'h0020);
    check_front("t2", 1'b0);

    // 3: frame waits, second frame overruns and is dropped
    randomize_frame();
    ph = $urandom_range(2, 4);
    cs_low();
    send_bits(256, ph);
    cs_high();
    model_commit(256);
    check("t3_pend", {15'd0, pend_a}, 16'd1);
    check_front("t3_old", 1'b0);
    randomize_frame();
    snap_a = cnt_done_a;
    cs_low();
    check("t3_ovr", {15'd0, ovr_a}, 16'd1);
    send_bits(256, ph);
    cs_high();
    check("t3_no_swap", 16'(cnt_done_a - snap_a), 16'd0);
    pulse_sync();
    model_swap();
    check("t3_done_once", 16'(cnt_done_a - snap_a), 16'd1);
    check_front("t3_new", 1'b0);

    // 4: aborted 40-bit frame, then a full all-ones frame
    randomize_frame();
    ph = $urandom_range(2, 4);
    snap_a = cnt_done_a;
    cs_low();
    send_bits(40, ph);
    cs_high();
    model_commit(40);
    check("t4_abort_pend", {15'd0, pend_a}, 16'd0);
    check_front("t4_abort", 1'b0);
    for (int r = 0; r < 16; r++) tx_words[r] = 16'hFFFF;
    cs_low();
    send_bits(256, ph);
    cs_high();
    model_commit(256);
    pulse_sync();
    model_swap();
    check("t4_done_once", 16'(cnt_done_a - snap_a), 16'd1);
    check_front("t4", 1'b0);

    // 5: reset in the middle of a row
    randomize_frame();
    ph = $urandom_range(2, 4);
    cs_low();
    send_bits(100, ph);
    reset = 1'b1;
    ser_cs_n = 1'b1;
    clk_wait(1);
    reset = 1'b0;
    model_clear();
    check("t5_rd",   rd_a, 16'd0);
    check("t5_pend", {15'd0, pend_a}, 16'd0);
    check("t5_done", {15'd0, done_a}, 16'd0);
    check("t5_ovr",  {15'd0, ovr_a},  16'd0);
    clk_wait(4);
    check_front("t5_zero", 1'b0);
    randomize_frame();
    cs_low();
    send_bits(256, ph);
    cs_high();
    model_commit(256);
    pulse_sync();
    model_swap();
    check_front("t5_reload", 1'b0);

    // 6: immediate-swap instance at the fastest serial clock
    reset = 1'b1;
    clk_wait(2);
    reset = 1'b0;
    model_clear();
    clk_wait(4);
    randomize_frame();
    snap_b = cnt_done_b;
    cs_low();
    send_bits(256, 2);
    clk_wait(3);
    model_commit(256);
    check("t6_done_b", 16'(cnt_done_b - snap_b), 16'd1);
    check("t6_pend_b", {15'd0, pend_b}, 16'd0);
    check("t6_pend_a", {15'd0, pend_a}, 16'd1);
    cs_high();
    check_front("t6", 1'b1);
    check_front("t6_hold", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
